axis_spm_control_rot: RTL and testbench

//  Next-gen SPM scan output stage. Rotates scan vector (xs,ys) by 2x2 matrix rotm, adds slew-limited

---
 rtl/spm_ctrl_pkg.sv | 29 ++
 rtl/spm_offset_slew.sv | 40 ++++
 rtl/axis_spm_control_rot.sv | 177 +++++++++++++++++
 tb/tb_axis_spm_control_rot.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_ctrl_pkg.sv
`default_nettype none
// spm_ctrl_pkg: channel indices, rotation defaults and saturation/rounding helpers
// shared by the SPM scan output stage. Rev 1.0
package spm_ctrl_pkg;

  localparam int CH_X = 0;
  localparam int CH_Y = 1;
  localparam int CH_Z = 2;
  localparam int CH_U = 3;

  localparam int Q_ROT_DEF = 30;

  // Clip a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_sw(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic signed [63:0] round_const(input int q);
    return (q > 0) ? (64'sd1 <<< (q - 1)) : 64'sd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_offset_slew.sv
`default_nettype none
// spm_offset_slew: moves an offset register toward its target by at most step per cycle.
// Rev 1.0
module spm_offset_slew #(
  parameter int W_IN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [W_IN-1:0] target,
  input  logic        [W_IN-1:0] step,
  output logic signed [W_IN-1:0] off,
  output logic                   busy
);

  logic signed [W_IN-1:0] off_q, off_d;
  logic signed [W_IN:0]   diff;
  logic        [W_IN:0]   mag;

  // One extra bit keeps the difference exact across the full signed range.
  always_comb begin
    diff = (W_IN+1)'(target) - (W_IN+1)'(off_q);
    mag  = diff[W_IN] ? unsigned'(-diff) : unsigned'(diff);
    if (mag <= {1'b0, step})
      off_d = target;
    else if (diff[W_IN])
      off_d = off_q - step;
    else
      off_d = off_q + step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) off_q <= '0;
    else     off_q <= off_d;
  end

  assign off  = off_q;
  assign busy = (off_q != target);

endmodule
`default_nettype wire

// File: rtl/axis_spm_control_rot.sv
`default_nettype none
// axis_spm_control_rot: rotates (xs,ys) by rotm, adds slewed offsets, saturates, drives X/Y/Z/U
// AXIS DAC feeds. SPM_CTRL_SATCNT_EN enables the saturated-cycle counter. Rev 1.0
module axis_spm_control_rot
  import spm_ctrl_pkg::*;
#(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int W_IN              = 32,
  parameter int Q_ROT             = Q_ROT_DEF
) (
  input  logic                          a_clk,
  input  logic                          a_reset,
  input  logic signed [W_IN-1:0]        rotm [4],
  input  logic signed [W_IN-1:0]        xs,
  input  logic signed [W_IN-1:0]        ys,
  input  logic signed [W_IN-1:0]        zs,
  input  logic signed [W_IN-1:0]        u,
  input  logic signed [W_IN-1:0]        x0,
  input  logic signed [W_IN-1:0]        y0,
  input  logic signed [W_IN-1:0]        z0,
  input  logic        [W_IN-1:0]        slew_step,
  input  logic                          sat_clr,
  output logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS1_tdata,
  output logic                          S_AXIS1_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS2_tdata,
  output logic                          S_AXIS2_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS3_tdata,
  output logic                          S_AXIS3_tvalid,
  output logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS4_tdata,
  output logic                          S_AXIS4_tvalid,
  output logic signed [W_IN-1:0]        xs_mon,
  output logic signed [W_IN-1:0]        ys_mon,
  output logic signed [W_IN-1:0]        zs_mon,
  output logic signed [W_IN-1:0]        u_mon,
  output logic signed [W_IN-1:0]        x0_mon,
  output logic signed [W_IN-1:0]        y0_mon,
  output logic signed [W_IN-1:0]        z0_mon,
  output logic                          slew_busy,
  output logic [3:0]                    sat,
  output logic [31:0]                   sat_count
);

  localparam int W_OUT = SAXIS_TDATA_WIDTH;
  localparam int PW    = 2 * W_IN;
  localparam int SW    = PW + 1;
  localparam int XW    = W_IN + 2;
  localparam int SH    = W_IN - W_OUT;

  logic signed [PW-1:0]   p_q [4];
  logic signed [PW-1:0]   p_d [4];
  logic signed [W_IN-1:0] mon_q [4];
  logic signed [W_IN-1:0] mon_d [4];
  logic signed [XW-1:0]   xr_q, xr_d, yr_q, yr_d;
  logic signed [W_IN-1:0] zs2_q, u2_q;
  logic [W_OUT-1:0]       tdata_q [4];
  logic [W_OUT-1:0]       tdata_d [4];
  logic [3:0]             sat_q, sat_d;
  logic [2:0]             vld_q, vld_d;

  logic signed [SW-1:0]   sx, sy;
  logic signed [XW-1:0]   ch [4];
  logic signed [63:0]     clp [4];
  logic [3:0]             clip;

  logic signed [W_IN-1:0] tgt [3];
  logic signed [W_IN-1:0] off [3];
  logic [2:0]             busy;

  assign tgt[0] = x0;
  assign tgt[1] = y0;
  assign tgt[2] = z0;

  for (genvar a = 0; a < 3; a++) begin : g_slew
    spm_offset_slew #(.W_IN(W_IN)) u_slew (
      .clk    (a_clk),
      .rst    (a_reset),
      .target (tgt[a]),
      .step   (slew_step),
      .off    (off[a]),
      .busy   (busy[a])
    );
  end

  always_comb begin
    p_d[0] = PW'(rotm[0]) * PW'(xs);
    p_d[1] = PW'(rotm[1]) * PW'(ys);
    p_d[2] = PW'(rotm[2]) * PW'(xs);
    p_d[3] = PW'(rotm[3]) * PW'(ys);
    mon_d  = '{xs, ys, zs, u};

    // Round half up, then drop the fraction; W_IN+2 bits leave headroom for the offset add.
    sx   = SW'(p_q[0]) + SW'(p_q[1]) + SW'(round_const(Q_ROT));
    sy   = SW'(p_q[2]) + SW'(p_q[3]) + SW'(round_const(Q_ROT));
    xr_d = XW'(sx >>> Q_ROT);
    yr_d = XW'(sy >>> Q_ROT);

    ch[CH_X] = XW'(off[0]) + xr_q;
    ch[CH_Y] = XW'(off[1]) + yr_q;
    ch[CH_Z] = XW'(off[2]) + XW'(zs2_q);
    ch[CH_U] = XW'(u2_q);
    for (int i = 0; i < 4; i++) begin
      clp[i]     = sat_sw(64'(ch[i]), W_IN);
      clip[i]    = (clp[i] != 64'(ch[i]));
      tdata_d[i] = W_OUT'(W_IN'(clp[i]) >>> SH);
    end

    sat_d = clip | (sat_q & ~{4{sat_clr}});
    vld_d = {vld_q[1:0], 1'b1};
  end

  always_ff @(posedge a_clk or posedge a_reset) begin
    if (a_reset) begin
      p_q     <= '{default: '0};
      mon_q   <= '{default: '0};
      xr_q    <= '0;
      yr_q    <= '0;
      zs2_q   <= '0;
      u2_q    <= '0;
      tdata_q <= '{default: '0};
      sat_q   <= '0;
      vld_q   <= '0;
    end else begin
      p_q     <= p_d;
      mon_q   <= mon_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      zs2_q   <= mon_q[2];
      u2_q    <= mon_q[3];
      tdata_q <= tdata_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
    end
  end

`ifdef SPM_CTRL_SATCNT_EN
  logic [31:0] cnt_q, cnt_d;

  // A clipping cycle that coincides with a clear restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (|clip)
      cnt_d = sat_clr ? 32'd1 : ((&cnt_q) ? cnt_q : cnt_q + 32'd1);
    else if (sat_clr)
      cnt_d = '0;
  end

  always_ff @(posedge a_clk or posedge a_reset) begin
    if (a_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
`endif

  assign S_AXIS1_tdata  = tdata_q[CH_X];
  assign S_AXIS2_tdata  = tdata_q[CH_Y];
  assign S_AXIS3_tdata  = tdata_q[CH_Z];
  assign S_AXIS4_tdata  = tdata_q[CH_U];
  assign S_AXIS1_tvalid = vld_q[2];
  assign S_AXIS2_tvalid = vld_q[2];
  assign S_AXIS3_tvalid = vld_q[2];
  assign S_AXIS4_tvalid = vld_q[2];

  assign xs_mon    = mon_q[0];
  assign ys_mon    = mon_q[1];
  assign zs_mon    = mon_q[2];
  assign u_mon     = mon_q[3];
  assign x0_mon    = off[0];
  assign y0_mon    = off[1];
  assign z0_mon    = off[2];
  assign slew_busy = |busy;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_spm_control_rot.sv
`default_nettype none
// Bench for axis_spm_control_rot: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the scan output stage.
module tb_axis_spm_control_rot;

  logic a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  logic               a_reset;
  logic signed [31:0] rotm [4];
  logic signed [31:0] xs, ys, zs, u, x0, y0, z0;
  logic [31:0]        slew_step;
  logic               sat_clr;
  logic [31:0]        td [4];
  logic               tv [4];
  logic signed [31:0] mon [4];
  logic signed [31:0] offm [3];
  logic               slew_busy;
  logic [3:0]         sat;
  logic [31:0]        sat_count;

  axis_spm_control_rot dut (
    .a_clk          (a_clk),
    .a_reset        (a_reset),
    .rotm           (rotm),
    .xs             (xs),
    .ys             (ys),
    .zs             (zs),
    .u              (u),
    .x0             (x0),
    .y0             (y0),
    .z0             (z0),
    .slew_step      (slew_step),
    .sat_clr        (sat_clr),
    .S_AXIS1_tdata  (td[0]),
    .S_AXIS1_tvalid (tv[0]),
    .S_AXIS2_tdata  (td[1]),
    .S_AXIS2_tvalid (tv[1]),
    .S_AXIS3_tdata  (td[2]),
    .S_AXIS3_tvalid (tv[2]),
    .S_AXIS4_tdata  (td[3]),
    .S_AXIS4_tvalid (tv[3]),
    .xs_mon         (mon[0]),
    .ys_mon         (mon[1]),
    .zs_mon         (mon[2]),
    .u_mon          (mon[3]),
    .x0_mon         (offm[0]),
    .y0_mon         (offm[1]),
    .z0_mon         (offm[2]),
    .slew_busy      (slew_busy),
    .sat            (sat),
    .sat_count      (sat_count)
  );

  // ---------------- behavioural model ----------------
  typedef struct { longint xr; longint yr; longint zs; longint u; } rent_t;
  rent_t       rq [$];
  longint      m_off [3];
  logic [31:0] e_td [4];
  logic        e_vld;
  logic [3:0]  e_sat;
  logic [31:0] e_cnt;
  longint      e_mon [4];
  int          vcnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic longint clip32(input longint v, output bit c);
    c = 1'b1;
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    c = 1'b0;
    return v;
  endfunction

  // Rotation row with round-half-up at Q30.
  function automatic longint rot(input longint a, input longint b, input longint x, input longint y);
    return (a * x + b * y + 64'sd536870912) >>> 30;
  endfunction

  function automatic longint slew(input longint off, input longint tgt, input longint stp);
    longint d;
    d = tgt - off;
    if (((d >= 0) ? d : -d) <= stp) return tgt;
    return (d > 0) ? off + stp : off - stp;
  endfunction

  function automatic logic exp_busy();
    return (m_off[0] != longint'(x0)) || (m_off[1] != longint'(y0)) || (m_off[2] != longint'(z0));
  endfunction

  task automatic model_reset();
    rent_t z;
    z = '{0, 0, 0, 0};
    rq.delete();
    rq.push_back(z);
    rq.push_back(z);
    m_off = '{0, 0, 0};
    e_td  = '{0, 0, 0, 0};
    e_mon = '{0, 0, 0, 0};
    e_vld = 1'b0;
    e_sat = 4'b0;
    e_cnt = 32'd0;
    vcnt  = 0;
  endtask

  task automatic model_edge();
    rent_t  e;
    rent_t  n;
    longint v [4];
    bit     c [4];
    bit     anyc;
    anyc = 1'b0;
    e = rq.pop_front();
    v[0] = m_off[0] + e.xr;
    v[1] = m_off[1] + e.yr;
    v[2] = m_off[2] + e.zs;
    v[3] = e.u;
    for (int i = 0; i < 4; i++) begin
      e_td[i]  = 32'(clip32(v[i], c[i]));
      anyc     = anyc | c[i];
      e_sat[i] = c[i] | (e_sat[i] & ~sat_clr);
    end
`ifdef SPM_CTRL_SATCNT_EN
    if (anyc) e_cnt = sat_clr ? 32'd1 : ((e_cnt == 32'hFFFF_FFFF) ? e_cnt : e_cnt + 32'd1);
    else if (sat_clr) e_cnt = 32'd0;
`endif
    n.xr = rot(rotm[0], rotm[1], xs, ys);
    n.yr = rot(rotm[2], rotm[3], xs, ys);
    n.zs = zs;
    n.u  = u;
    rq.push_back(n);
    e_mon = '{xs, ys, zs, u};
    m_off[0] = slew(m_off[0], x0, slew_step);
    m_off[1] = slew(m_off[1], y0, slew_step);
    m_off[2] = slew(m_off[2], z0, slew_step);
    if (vcnt < 3) vcnt++;
    e_vld = (vcnt >= 3);
  endtask

  task automatic tick();
    @(posedge a_clk);
    if (a_reset) model_reset();
    else         model_edge();
    #1;
  endtask

  task automatic set_identity();
    rotm = '{32'sd1073741824, 32'sd0, 32'sd0, 32'sd1073741824};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_reset = 1'b1;
    set_identity();
    xs = 32'sd1000; ys = 0; zs = 0; u = 0;
    x0 = 0; y0 = 0; z0 = 0;
    slew_step = 32'd0;
    sat_clr = 1'b0;
    model_reset();
    @(posedge a_clk); #1;
    n_checks++;
    if ({td[0], td[1], td[2], td[3]} !== 128'd0 || {tv[0], tv[1], tv[2], tv[3]} !== 4'b0)
      $display("FAIL reset_out: tdata %h %h %h %h tvalid %b%b%b%b, want all 0",
               td[0], td[1], td[2], td[3], tv[0], tv[1], tv[2], tv[3]);
    else n_pass++;
    n_checks++;
    if ({offm[0], offm[1], offm[2], mon[0]} !== 128'd0 || sat !== 4'b0 || sat_count !== 32'd0)
      $display("FAIL reset_state: offs %h %h %h xs_mon %h sat %b cnt %0d, want 0",
               offm[0], offm[1], offm[2], mon[0], sat, sat_count);
    else n_pass++;
    a_reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if ({tv[0], tv[1], tv[2], tv[3]} !== {4{k == 3}})
        $display("FAIL tvalid_rise: edge %0d got %b%b%b%b want %b", k, tv[0], tv[1], tv[2], tv[3], k == 3);
      else n_pass++;
    end
    n_checks++;
    if (td[0] !== 32'd1000 || td[0] !== e_td[0])
      $display("FAIL identity_x: got %0d want 1000", $signed(td[0]));
    else n_pass++;
  endtask

  task automatic test_rot90();
    rotm = '{32'sd0, -32'sd1073741824, 32'sd1073741824, 32'sd0};
    xs = 32'sd1000; ys = 0;
    repeat (3) tick();
    n_checks++;
    if (td[0] !== 32'd0 || td[1] !== 32'd1000 || td[0] !== e_td[0] || td[1] !== e_td[1])
      $display("FAIL rot90_a: X %0d Y %0d want 0 1000", $signed(td[0]), $signed(td[1]));
    else n_pass++;
    xs = 0; ys = 32'sd1000;
    repeat (3) tick();
    n_checks++;
    if (td[0] !== 32'hFFFF_FC18 || td[1] !== 32'd0 || td[0] !== e_td[0] || td[1] !== e_td[1])
      $display("FAIL rot90_b: X %0d Y %0d want -1000 0", $signed(td[0]), $signed(td[1]));
    else n_pass++;
  endtask

  task automatic test_slew();
    set_identity();
    xs = 0; ys = 0;
    repeat (3) tick();
    slew_step = 32'd100;
    x0 = 32'sd1000;
    #1;
    n_checks++;
    if (slew_busy !== 1'b1) $display("FAIL slew_busy_start: got %b want 1", slew_busy);
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (offm[0] !== 32'(100 * k) || slew_busy !== (k < 10) || td[0] !== 32'(100 * (k - 1)) ||
          td[0] !== e_td[0])
        $display("FAIL slew_step%0d: x0_mon %0d busy %b X %0d want %0d %b %0d",
                 k, offm[0], slew_busy, $signed(td[0]), 100 * k, k < 10, 100 * (k - 1));
      else n_pass++;
    end
    tick();
    n_checks++;
    if (td[0] !== 32'd1000) $display("FAIL slew_final_x: got %0d want 1000", $signed(td[0]));
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [31:0] want_cnt;
    set_identity();
    slew_step = 32'hFFFF_FFFF;
    x0 = 32'sh7FFF_0000;
    xs = 32'sh7FFF_0000;
    ys = 0;
    repeat (2) tick();
    n_checks++;
    if (sat !== 4'b0 || sat_count !== 32'd0 || x0_ok() == 1'b0)
      $display("FAIL sat_pre: sat %b cnt %0d x0_mon %h want 0 0 7fff0000", sat, sat_count, offm[0]);
    else n_pass++;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
`ifdef SPM_CTRL_SATCNT_EN
    want_cnt = 32'd1;
`else
    want_cnt = 32'd0;
`endif
    n_checks++;
    if (td[0] !== 32'h7FFF_FFFF || sat[0] !== 1'b1 || sat_count !== want_cnt || sat_count !== e_cnt)
      $display("FAIL sat_pos_clr: X %h sat %b cnt %0d want 7fffffff 1 %0d", td[0], sat, sat_count, want_cnt);
    else n_pass++;
    repeat (4) tick();
`ifdef SPM_CTRL_SATCNT_EN
    want_cnt = 32'd5;
`endif
    n_checks++;
    if (td[0] !== 32'h7FFF_FFFF || sat_count !== want_cnt)
      $display("FAIL sat_count5: X %h cnt %0d want 7fffffff %0d", td[0], sat_count, want_cnt);
    else n_pass++;
    x0 = 0; xs = 0;
    repeat (4) tick();
    n_checks++;
    if (td[0] !== 32'd0 || sat[0] !== 1'b1 || sat !== e_sat)
      $display("FAIL sat_sticky: X %h sat %b want 0 sat0=1", td[0], sat);
    else n_pass++;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    n_checks++;
    if (sat !== 4'b0 || sat_count !== 32'd0)
      $display("FAIL sat_clear: sat %b cnt %0d want 0 0", sat, sat_count);
    else n_pass++;
    x0 = 32'sh8001_0000;
    xs = -32'sh7FFF_0000;
    repeat (3) tick();
    n_checks++;
    if (td[0] !== 32'h8000_0000 || sat[0] !== 1'b1 || td[0] !== e_td[0])
      $display("FAIL sat_neg: X %h sat %b want 80000000 sat0=1", td[0], sat);
    else n_pass++;
    x0 = 0; xs = 0;
    repeat (4) tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
  endtask

  function automatic logic x0_ok();
    return offm[0] === 32'sh7FFF_0000;
  endfunction

  task automatic test_reset_mid_ramp();
    xs = 0; ys = 0;
    slew_step = 32'd100;
    x0 = 32'sd1000;
    repeat (5) tick();
    n_checks++;
    if (offm[0] !== 32'sd500) $display("FAIL ramp_mid: x0_mon %0d want 500", offm[0]);
    else n_pass++;
    #1;
    a_reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({td[0], td[1], td[2], td[3]} !== 128'd0 || {tv[0], tv[1], tv[2], tv[3]} !== 4'b0 || offm[0] !== 32'sd0)
      $display("FAIL async_reset: X %h tvalid %b x0_mon %0d want 0 0 0", td[0], tv[0], offm[0]);
    else n_pass++;
    tick();
    a_reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (offm[0] !== 32'(100 * k) || tv[0] !== (k == 3))
        $display("FAIL ramp_restart%0d: x0_mon %0d tvalid %b want %0d %b", k, offm[0], tv[0], 100 * k, k == 3);
      else n_pass++;
    end
  endtask

  function automatic logic signed [31:0] rnd_unit();
    return 32'(longint'($urandom_range(0, 32'h8000_0000)) - 64'sh4000_0000);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 4; i++) rotm[i] = rnd_unit();
      xs = rnd_unit();
      ys = rnd_unit();
      zs = $urandom;
      u  = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        x0 = $urandom; y0 = $urandom; z0 = $urandom;
      end
      case ($urandom_range(0, 3))
        0:       slew_step = 32'd0;
        1:       slew_step = $urandom_range(1, 1000);
        2:       slew_step = $urandom;
        default: slew_step = 32'hFFFF_FFFF;
      endcase
      sat_clr = ($urandom_range(0, 7) == 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (td[i] !== e_td[i] || tv[i] !== e_vld)
          $display("FAIL rnd_ch%0d cyc %0d: tdata %h tvalid %b want %h %b", i, c, td[i], tv[i], e_td[i], e_vld);
        else n_pass++;
      end
      n_checks++;
      if (mon[0] !== 32'(e_mon[0]) || mon[1] !== 32'(e_mon[1]) ||
          mon[2] !== 32'(e_mon[2]) || mon[3] !== 32'(e_mon[3]))
        $display("FAIL rnd_mon cyc %0d: %h %h %h %h want %h %h %h %h", c, mon[0], mon[1], mon[2], mon[3],
                 32'(e_mon[0]), 32'(e_mon[1]), 32'(e_mon[2]), 32'(e_mon[3]));
      else n_pass++;
      n_checks++;
      if (offm[0] !== 32'(m_off[0]) || offm[1] !== 32'(m_off[1]) || offm[2] !== 32'(m_off[2]) ||
          slew_busy !== exp_busy())
        $display("FAIL rnd_off cyc %0d: %h %h %h busy %b want %h %h %h %b", c, offm[0], offm[1], offm[2],
                 slew_busy, 32'(m_off[0]), 32'(m_off[1]), 32'(m_off[2]), exp_busy());
      else n_pass++;
      n_checks++;
      if (sat !== e_sat || sat_count !== e_cnt)
        $display("FAIL rnd_sat cyc %0d: sat %b cnt %0d want %b %0d", c, sat, sat_count, e_sat, e_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rot90();
    test_slew();
    test_saturation();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
